fpu_except_resolve: RTL and testbench
=====================================

Name: fpu_except_resolve

Overview:
- Sits directly downstream of the FPU exception/special-numbers unit and consumes its registered classification flags.
- Aligns the operands and opcode with those flags through an internal delay pipeline.
- Decides whether the IEEE-754 single-precision result is a forced special value (NaN, Inf or signed zero), and raises invalid/divide-by-zero.
- Maintains sticky status bits for the FPU status register.

Parameters:
- QNAN_CANON, 32'h7FC00000, canonical quiet NaN returned for invalid operations.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/opcode presented this cycle; same cycle the exception unit samples them
- fpu_op  in  2  0=add, 1=sub, 2=mul, 3=div
- opa, opb  in  32  operands, same cycle as in_valid
- opa_nan, opb_nan  in  1  exception-unit flags, valid 1 cycle after operands
- opa_inf, opb_inf, opa_00, opb_00, qnan, snan  in  1  exception-unit flags, valid 2 cycles after operands
- out_valid  out  1  one-cycle pulse; result for an accepted operand pair
- special  out  1  result is forced by this block (normal datapath result to be discarded)
- special_res  out  32  forced result
- invalid  out  1  invalid-operation flag for this result
- div_zero  out  1  divide-by-zero flag for this result
- sticky_invalid, sticky_dz  out  1  accumulated flags
- clr_sticky  in  1  clears the sticky bits

Behaviour:
- Reset (async, rst_n=0): all pipeline valid bits, out_valid, special, invalid, div_zero, sticky bits = 0; special_res = 0. Anything in flight is discarded. Flags arriving after reset release for pre-reset operands are ignored because their valid bits were cleared.
- Pipeline: no backpressure; one operation may enter every cycle.
  - Stage 1 registers valid, fpu_op, opa, opb.
  - Stage 2 registers the same fields, plus opa_nan/opb_nan delayed one cycle.
  - At stage 2 all flags are aligned, and the decision logic is combinational.
  - The output register loads at the next edge.
- Latency: in_valid at cycle N produces out_valid at cycle N+3. Back-to-back inputs give back-to-back outputs.
- sa = opa[31]. sb = opb[31] ^ (fpu_op==sub), i.e. the effective opb sign. sx = opa[31]^opb[31].
- Decision priority (first match wins), evaluated on aligned values:
  1. snan: special=1, invalid=1. Result is opa with bit22 forced 1 if opa_nan, else opb with bit22 forced 1.
  2. qnan (no snan): special=1, invalid=0. Result is opa if opa_nan, else opb, unmodified.
  3. add/sub, opa_inf & opb_inf & sa!=sb: invalid=1, result QNAN_CANON.
  4. add/sub, any inf: result {sa or sb of the inf operand, 8'hFF, 23'h0}. opa takes precedence when both are inf with the same sign.
  5. mul: (opa_inf&opb_00)|(opb_inf&opa_00) gives invalid=1, QNAN_CANON. Any other inf gives {sx,8'hFF,0}. Any zero gives {sx,31'h0}.
  6. div: (opa_00&opb_00)|(opa_inf&opb_inf) gives invalid=1, QNAN_CANON.
     - opb_00: div_zero=1, {sx,8'hFF,0}.
     - opa_inf: {sx,8'hFF,0}.
     - opb_inf or opa_00: {sx,31'h0}.
  7. Otherwise special=0, invalid=0, div_zero=0; special_res = 0.
- When out_valid=0: special, invalid, div_zero = 0; special_res holds its last value.
- Sticky bits: on an out_valid cycle with invalid (resp. div_zero) set, the corresponding sticky bit goes to 1. clr_sticky clears both. If set and clear fall in the same cycle, set wins (result 1). Sticky bits are otherwise held.
- Denormal operands are not special here; they pass to the normal path (special=0).

Test Plan:
- Reset mid-flight: in_valid at cycle 0, rst_n low at cycle 1 for 1 cycle -> out_valid never asserts; all outputs 0.
- add opa=7F800000, opb=7F800000 -> at cycle 3: out_valid=1, special=1, special_res=7F800000, invalid=0. sub with the same operands -> special_res=7FC00000, invalid=1, sticky_invalid=1.
- div opa=3F800000, opb=80000000 -> special_res=FF800000, div_zero=1, sticky_dz=1. Next: clr_sticky with no new flag -> sticky_dz=0.
- mul opa=7FA00001 (sNaN), opb=3F800000 -> special_res=7FE00001, invalid=1. mul opa=3F800000, opb=7FC00005 -> special_res=7FC00005, invalid=0.
- Back-to-back: 4 consecutive in_valid (mul 0×inf, div 0/0, add 1+2, div inf/2) -> 4 consecutive out_valid with (invalid, 7FC00000), (invalid, 7FC00000), (special=0), (special_res=7F800000).
- Sticky collision: an invalid result lands in the same cycle as clr_sticky -> sticky_invalid=1 afterwards.

Source files
------------

// File: rtl/fpu_except_resolve.sv
// Resolves forced special results (NaN/Inf/signed zero) for the FPU.
// Aligns operands with late exception-unit flags and keeps sticky status.
module fpu_except_resolve #(
  parameter logic [31:0] QNAN_CANON = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  fpu_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        opa_nan,
  input  logic        opb_nan,
  input  logic        opa_inf,
  input  logic        opb_inf,
  input  logic        opa_00,
  input  logic        opb_00,
  input  logic        qnan,
  input  logic        snan,
  input  logic        clr_sticky,
  output logic        out_valid,
  output logic        special,
  output logic [31:0] special_res,
  output logic        invalid,
  output logic        div_zero,
  output logic        sticky_invalid,
  output logic        sticky_dz
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  logic        s1_vld_q;
  logic [1:0]  s1_op_q;
  logic [31:0] s1_a_q;
  logic [31:0] s1_b_q;

  logic        s2_vld_q;
  logic [1:0]  s2_op_q;
  logic [31:0] s2_a_q;
  logic [31:0] s2_b_q;
  logic        s2_anan_q;
  logic        s2_bnan_q;

  logic        vld_q;
  logic        spec_q;
  logic [31:0] res_q;
  logic        inv_q;
  logic        dz_q;
  logic        st_inv_q;
  logic        st_dz_q;

  logic        spec_d;
  logic [31:0] res_d;
  logic        inv_d;
  logic        dz_d;
  logic        st_inv_d;
  logic        st_dz_d;

  logic sa;
  logic sb;
  logic sx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_op_q   <= 2'd0;
      s1_a_q    <= 32'h0;
      s1_b_q    <= 32'h0;
      s2_vld_q  <= 1'b0;
      s2_op_q   <= 2'd0;
      s2_a_q    <= 32'h0;
      s2_b_q    <= 32'h0;
      s2_anan_q <= 1'b0;
      s2_bnan_q <= 1'b0;
    end else begin
      s1_vld_q  <= in_valid;
      s1_op_q   <= fpu_op;
      s1_a_q    <= opa;
      s1_b_q    <= opb;
      s2_vld_q  <= s1_vld_q;
      s2_op_q   <= s1_op_q;
      s2_a_q    <= s1_a_q;
      s2_b_q    <= s1_b_q;
      s2_anan_q <= opa_nan;
      s2_bnan_q <= opb_nan;
    end
  end

  assign sa = s2_a_q[31];
  assign sb = s2_b_q[31] ^ (s2_op_q == OP_SUB);
  assign sx = s2_a_q[31] ^ s2_b_q[31];

  // NaN handling outranks every opcode-specific rule.
  always_comb begin
    spec_d = 1'b0;
    res_d  = 32'h0;
    inv_d  = 1'b0;
    dz_d   = 1'b0;
    if (snan) begin
      spec_d = 1'b1;
      inv_d  = 1'b1;
      res_d  = s2_anan_q ? s2_a_q : s2_b_q;
      res_d[22] = 1'b1;
    end else if (qnan) begin
      spec_d = 1'b1;
      res_d  = s2_anan_q ? s2_a_q : s2_b_q;
    end else begin
      unique case (s2_op_q)
        OP_ADD, OP_SUB: begin
          if (opa_inf && opb_inf && (sa != sb)) begin
            spec_d = 1'b1;
            inv_d  = 1'b1;
            res_d  = QNAN_CANON;
          end else if (opa_inf) begin
            spec_d = 1'b1;
            res_d  = {sa, 8'hFF, 23'h0};
          end else if (opb_inf) begin
            spec_d = 1'b1;
            res_d  = {sb, 8'hFF, 23'h0};
          end
        end
        OP_MUL: begin
          if ((opa_inf && opb_00) || (opb_inf && opa_00)) begin
            spec_d = 1'b1;
            inv_d  = 1'b1;
            res_d  = QNAN_CANON;
          end else if (opa_inf || opb_inf) begin
            spec_d = 1'b1;
            res_d  = {sx, 8'hFF, 23'h0};
          end else if (opa_00 || opb_00) begin
            spec_d = 1'b1;
            res_d  = {sx, 31'h0};
          end
        end
        OP_DIV: begin
          if ((opa_00 && opb_00) || (opa_inf && opb_inf)) begin
            spec_d = 1'b1;
            inv_d  = 1'b1;
            res_d  = QNAN_CANON;
          end else if (opb_00) begin
            spec_d = 1'b1;
            dz_d   = 1'b1;
            res_d  = {sx, 8'hFF, 23'h0};
          end else if (opa_inf) begin
            spec_d = 1'b1;
            res_d  = {sx, 8'hFF, 23'h0};
          end else if (opb_inf || opa_00) begin
            spec_d = 1'b1;
            res_d  = {sx, 31'h0};
          end
        end
        default: ;
      endcase
    end
  end

  // A set from the presented result beats a same-cycle clear.
  assign st_inv_d = (vld_q & inv_q) | (st_inv_q & ~clr_sticky);
  assign st_dz_d  = (vld_q & dz_q)  | (st_dz_q  & ~clr_sticky);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      spec_q   <= 1'b0;
      res_q    <= 32'h0;
      inv_q    <= 1'b0;
      dz_q     <= 1'b0;
      st_inv_q <= 1'b0;
      st_dz_q  <= 1'b0;
    end else begin
      vld_q    <= s2_vld_q;
      spec_q   <= s2_vld_q & spec_d;
      inv_q    <= s2_vld_q & inv_d;
      dz_q     <= s2_vld_q & dz_d;
      st_inv_q <= st_inv_d;
      st_dz_q  <= st_dz_d;
      if (s2_vld_q) begin
        res_q <= res_d;
      end
    end
  end

  assign out_valid      = vld_q;
  assign special        = spec_q;
  assign special_res    = res_q;
  assign invalid        = inv_q;
  assign div_zero       = dz_q;
  assign sticky_invalid = st_inv_q;
  assign sticky_dz      = st_dz_q;

endmodule

// File: tb/tb_fpu_except_resolve.sv
// Scoreboard bench for fpu_except_resolve.
// Emulates the upstream exception unit's delayed flags.
module tb_fpu_except_resolve;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  fpu_op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        opa_nan;
  logic        opb_nan;
  logic        opa_inf;
  logic        opb_inf;
  logic        opa_00;
  logic        opb_00;
  logic        qnan;
  logic        snan;
  logic        clr_sticky;
  logic        out_valid;
  logic        special;
  logic [31:0] special_res;
  logic        invalid;
  logic        div_zero;
  logic        sticky_invalid;
  logic        sticky_dz;

  fpu_except_resolve dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .fpu_op(fpu_op),
    .opa(opa),
    .opb(opb),
    .opa_nan(opa_nan),
    .opb_nan(opb_nan),
    .opa_inf(opa_inf),
    .opb_inf(opb_inf),
    .opa_00(opa_00),
    .opb_00(opb_00),
    .qnan(qnan),
    .snan(snan),
    .clr_sticky(clr_sticky),
    .out_valid(out_valid),
    .special(special),
    .special_res(special_res),
    .invalid(invalid),
    .div_zero(div_zero),
    .sticky_invalid(sticky_invalid),
    .sticky_dz(sticky_dz)
  );

  typedef struct packed {
    logic anan;
    logic bnan;
    logic ainf;
    logic binf;
    logic a00;
    logic b00;
    logic qn;
    logic sn;
  } cls_t;

  typedef struct {
    logic        spec;
    logic [31:0] res;
    logic        inv;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  cls_t h1;
  cls_t h2;
  int   cyc;
  int   n_chk;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic cls_t classify(input logic v,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    cls_t c;
    logic an, bn;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    c.anan = v & an;
    c.bnan = v & bn;
    c.ainf = v & (a[30:0] == 31'h7F80_0000);
    c.binf = v & (b[30:0] == 31'h7F80_0000);
    c.a00  = v & (a[30:0] == 31'h0);
    c.b00  = v & (b[30:0] == 31'h0);
    c.qn   = v & ((an & a[22]) | (bn & b[22]));
    c.sn   = v & ((an & ~a[22]) | (bn & ~b[22]));
    return c;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @cyc %0d",
               nm, act, req, cyc);
    end
  endtask

  // One cycle of stimulus; upstream flags trail their operands.
  task automatic step(input logic v, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic clr);
    @(negedge clk);
    h2 = h1;
    h1 = classify(in_valid, opa, opb);
    opa_nan = h1.anan;
    opb_nan = h1.bnan;
    opa_inf = h2.ainf;
    opb_inf = h2.binf;
    opa_00  = h2.a00;
    opb_00  = h2.b00;
    qnan    = h2.qn;
    snan    = h2.sn;
    in_valid   = v;
    fpu_op     = op;
    opa        = a;
    opb        = b;
    clr_sticky = clr;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic sp, input logic [31:0] r,
                       input logic iv, input logic dz);
    exp_t e;
    step(1'b1, op, a, b, 1'b0);
    e.spec = sp;
    e.res  = r;
    e.inv  = iv;
    e.dz   = dz;
    e.cyc  = cyc + 3;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 0, 0, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      idle(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    idle(1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("latency", cyc, e.cyc);
          chk("special", special, e.spec);
          chk("special_res", special_res, e.res);
          chk("invalid", invalid, e.inv);
          chk("div_zero", div_zero, e.dz);
        end
      end else begin
        chk("idle_flags", {special, invalid, div_zero}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    h1 = '0;
    h2 = '0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    fpu_op = 2'd0;
    opa = 0;
    opb = 0;
    {opa_nan, opb_nan, opa_inf, opb_inf} = 4'b0;
    {opa_00, opb_00, qnan, snan} = 4'b0;
    clr_sticky = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", special_res, 0);
    chk("rst_sticky", {sticky_invalid, sticky_dz}, 0);
    rst_n = 1'b1;

    // Reset with an operation in flight.
    step(1'b1, 2'd0, 32'h7F80_0000, 32'h7F80_0000, 1'b0);
    step(1'b0, 2'd0, 0, 0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 2'd0, 0, 0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, 0, 0, 1'b0);
      chk("flight_out_valid", out_valid, 0);
    end
    chk("flight_res", special_res, 0);
    chk("flight_sticky", {sticky_invalid, sticky_dz}, 0);

    issue(2'd0, 32'h7F80_0000, 32'h7F80_0000,
          1, 32'h7F80_0000, 0, 0);
    drain();
    chk("sticky_inv_add", sticky_invalid, 0);
    issue(2'd1, 32'h7F80_0000, 32'h7F80_0000,
          1, 32'h7FC0_0000, 1, 0);
    drain();
    chk("sticky_inv_sub", sticky_invalid, 1);

    issue(2'd3, 32'h3F80_0000, 32'h8000_0000,
          1, 32'hFF80_0000, 0, 1);
    drain();
    chk("sticky_dz_set", sticky_dz, 1);
    step(1'b0, 2'd0, 0, 0, 1'b1);
    step(1'b0, 2'd0, 0, 0, 1'b0);
    chk("sticky_dz_clr", sticky_dz, 0);
    chk("sticky_inv_clr", sticky_invalid, 0);

    issue(2'd2, 32'h7FA0_0001, 32'h3F80_0000,
          1, 32'h7FE0_0001, 1, 0);
    issue(2'd2, 32'h3F80_0000, 32'h7FC0_0005,
          1, 32'h7FC0_0005, 0, 0);
    issue(2'd2, 32'h7FC0_0001, 32'hFF80_0001,
          1, 32'h7FC0_0001, 1, 0);
    drain();

    // Back-to-back stream.
    issue(2'd2, 32'h0000_0000, 32'h7F80_0000,
          1, 32'h7FC0_0000, 1, 0);
    issue(2'd3, 32'h0000_0000, 32'h0000_0000,
          1, 32'h7FC0_0000, 1, 0);
    issue(2'd0, 32'h3F80_0000, 32'h4000_0000,
          0, 32'h0, 0, 0);
    issue(2'd3, 32'h7F80_0000, 32'h4000_0000,
          1, 32'h7F80_0000, 0, 0);
    issue(2'd1, 32'h3F80_0000, 32'h7F80_0000,
          1, 32'hFF80_0000, 0, 0);
    issue(2'd2, 32'h0000_0001, 32'h3F80_0000,
          0, 32'h0, 0, 0);
    issue(2'd3, 32'h8000_0000, 32'h3F80_0000,
          1, 32'h8000_0000, 0, 0);
    drain();

    // Sticky set and clear landing together.
    step(1'b0, 2'd0, 0, 0, 1'b1);
    step(1'b0, 2'd0, 0, 0, 1'b0);
    chk("coll_pre", sticky_invalid, 0);
    issue(2'd1, 32'hFF80_0000, 32'hFF80_0000,
          1, 32'h7FC0_0000, 1, 0);
    idle(2);
    step(1'b0, 2'd0, 0, 0, 1'b1);
    step(1'b0, 2'd0, 0, 0, 1'b0);
    chk("coll_sticky_inv", sticky_invalid, 1);
    chk("coll_sticky_dz", sticky_dz, 0);
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
